node_charge_keeper: RTL and testbench
=====================================

NODE_CHARGE_KEEPER -- requirements
Module: node_charge_keeper

Interface
REQ-001 Parameter NDRV, default 4: number of driver ports resolved onto the node (legal 1..16).
REQ-002 Parameter DECAY_CYCLES, default 16: cycles a floating node retains charge before becoming undriven (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 drv_in  input  NDRV*`W  packed driver values in the 3-bit strength/level encoding; port k occupies bits [3k+2:3k].
REQ-006 node_out  output  `W  registered resolved node value, same encoding.
REQ-007 hi  output  1  registered; 1 when node_out is driven or floating with level HI.
REQ-008 contention  output  1  registered one-cycle pulse per cycle of equal-strength conflicting drive.
REQ-009 decayed  output  1  registered; 1 while the state is DECAYED.

Function
REQ-010 Encoding shall be: 00x undriven, 010 float-1, 011 float-0, 100 weak-1, 101 weak-0, 110 strong-1, 111 strong-0; level bit 0 = HI, 1 = LO.
REQ-011 Resolved value r shall be the numerically largest of all NDRV drv_in fields, so strong beats weak beats floating beats undriven, and at equal strength LO beats HI.
REQ-012 State machine shall have three states: DRIVEN, HOLD, DECAYED.
REQ-013 The block shall keep a stored level register lvl_q and an 8-bit decay counter cnt_q.
REQ-014 r strength weak or strong -> next state DRIVEN; node_out <= r; lvl_q <= r level; cnt_q <= 0.
REQ-015 r floating -> next state HOLD; node_out <= r; lvl_q <= r level; cnt_q <= 0.
REQ-016 r undriven in DRIVEN -> next state HOLD; node_out <= {float, lvl_q}; cnt_q <= 1.
REQ-017 r undriven in HOLD, cnt_q < DECAY_CYCLES -> stay HOLD; node_out <= {float, lvl_q}; cnt_q increments.
REQ-018 r undriven in HOLD, cnt_q == DECAY_CYCLES -> DECAYED; node_out <= 000; cnt_q <= 0.
REQ-019 r undriven in DECAYED -> stay DECAYED; node_out holds 000.
REQ-020 A floating node therefore reports float for exactly DECAY_CYCLES cycles after the last drive, then undriven on the next cycle.
REQ-021 A continuously floating input (charge sharing via pass transistor) shall keep the node in HOLD indefinitely with cnt_q held at 0.
REQ-022 Contention shall be detected when at least two inputs share the maximum strength, that strength is weak or strong, and their levels differ; contention <= 1 for that cycle, else 0.
REQ-023 Floating-strength conflicts shall not assert contention; LO still wins per REQ-011.
REQ-024 hi <= 1 when next node_out strength != 00 and next level == HI, else 0.
REQ-025 decayed <= 1 exactly when next state is DECAYED.
REQ-026 Latency from drv_in to all outputs shall be one clock.
REQ-027 cnt_q shall never exceed DECAY_CYCLES; no wrap-around.

Reset
REQ-028 reset high at a rising edge shall force: state DECAYED, node_out 000, lvl_q 0 (HI), cnt_q 0, hi 0, contention 0, decayed 1.
REQ-029 reset shall take priority over all drv_in activity, including mid-HOLD countdown; the first post-reset cycle resolves drv_in normally.

Verification
REQ-030 Reset then all drv_in 000 -> node_out 000, decayed 1, hi 0, held indefinitely.
REQ-031 Port 0 = 110 one cycle, then all 000 (DECAY_CYCLES=16) -> node_out 110, then 010 for 16 cycles, hi 1 throughout, then 000 with decayed 1.
REQ-032 Port 0 = 110, port 1 = 111 -> node_out 111, hi 0, contention 1 each cycle; port 1 = 101 -> node_out 110, contention 0.
REQ-033 Port 2 = 100, port 3 = 011 -> node_out 100, contention 0; then port 2 = 000 -> node_out 011, HOLD, cnt_q stays 0 while port 3 floats.
REQ-034 Drive 111, release, assert reset at 5th HOLD cycle -> next node_out 000, decayed 1, cnt_q 0; release reset with port 0 = 100 -> node_out 100 one cycle later.
REQ-035 NDRV=1, DECAY_CYCLES=1: drive 101 then release -> 101, 011 for one cycle, then 000.

Source files
------------

// File: rtl/node_charge_keeper.sv
// Charge-keeping resolver for a multi-driver node.
// Resolves drivers, holds floating charge, then decays to undriven.
module node_charge_keeper #(
    parameter int NDRV         = 4,
    parameter int DECAY_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NDRV*3-1:0] drv_in,
    output logic [2:0]        node_out,
    output logic              hi,
    output logic              contention,
    output logic              decayed
);

    localparam logic [7:0] DC    = 8'(DECAY_CYCLES);
    localparam logic [1:0] S_FLT = 2'b01;

    typedef enum logic [1:0] {
        DRIVEN,
        HOLD,
        DECAYED
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] node_q, node_d;
    logic       lvl_q, lvl_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hi_q, hi_d;
    logic       cont_q, cont_d;
    logic       dec_q, dec_d;

    logic [2:0] r;
    logic       has_hi;
    logic       has_lo;

    // Resolve: the numerically largest field wins.
    always_comb begin
        r = 3'b000;
        for (int k = 0; k < NDRV; k++) begin
            if (drv_in[3*k +: 3] > r) begin
                r = drv_in[3*k +: 3];
            end
        end
    end

    // Collect levels of all drivers sharing the winning strength.
    always_comb begin
        has_hi = 1'b0;
        has_lo = 1'b0;
        for (int k = 0; k < NDRV; k++) begin
            if (drv_in[3*k+1 +: 2] == r[2:1]) begin
                if (drv_in[3*k]) begin
                    has_lo = 1'b1;
                end else begin
                    has_hi = 1'b1;
                end
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        if (r[2]) begin
            state_d = DRIVEN;
            node_d  = r;
            lvl_d   = r[0];
            cnt_d   = 8'd0;
        end else if (r[1]) begin
            state_d = HOLD;
            node_d  = r;
            lvl_d   = r[0];
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                DRIVEN: begin
                    state_d = HOLD;
                    node_d  = {S_FLT, lvl_q};
                    cnt_d   = 8'd1;
                end
                HOLD: begin
                    if (cnt_q < DC) begin
                        node_d = {S_FLT, lvl_q};
                        cnt_d  = cnt_q + 8'd1;
                    end else begin
                        state_d = DECAYED;
                        node_d  = 3'b000;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = DECAYED;
                    node_d  = 3'b000;
                    cnt_d   = 8'd0;
                end
            endcase
        end
        hi_d   = (node_d[2:1] != 2'b00) && !node_d[0];
        cont_d = r[2] && has_hi && has_lo;
        dec_d  = (state_d == DECAYED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DECAYED;
            node_q  <= 3'b000;
            lvl_q   <= 1'b0;
            cnt_q   <= 8'd0;
            hi_q    <= 1'b0;
            cont_q  <= 1'b0;
            dec_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            cont_q  <= cont_d;
            dec_q   <= dec_d;
        end
    end

    assign node_out   = node_q;
    assign hi         = hi_q;
    assign contention = cont_q;
    assign decayed    = dec_q;

endmodule

// File: tb/tb_node_charge_keeper.sv
// Scoreboard bench for node_charge_keeper.
// Expected {node,hi,contention,decayed} queued per driven cycle.
module tb_node_charge_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] drv = '0;
    logic [2:0]  node;
    logic        hi, cont, dec;
    logic [2:0]  drv1 = '0;
    logic [2:0]  node1;
    logic        hi1, cont1, dec1;

    logic [5:0] q[$];
    logic [5:0] q1[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    node_charge_keeper #(.NDRV(4), .DECAY_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .drv_in(drv),
        .node_out(node), .hi(hi), .contention(cont), .decayed(dec)
    );

    node_charge_keeper #(.NDRV(1), .DECAY_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .drv_in(drv1),
        .node_out(node1), .hi(hi1), .contention(cont1), .decayed(dec1)
    );

    function automatic logic [11:0] pk(input logic [2:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic apply(input logic r, input logic [11:0] d, input logic [5:0] e);
        @(negedge clk);
        reset = r;
        drv   = d;
        q.push_back(e);
    endtask

    task automatic test_reset;
        logic [5:0] e;
        logic [5:0] g;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) apply(1'b1, pk(3'b110, 3'b111, 3'b100, 3'b010), 6'b000_001);
            else        apply(1'b0, 12'h000, 6'b000_001);
            @(posedge clk); #1;
            e = q.pop_front();
            g = {node, hi, cont, dec};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    task automatic test_decay;
        logic [5:0] e;
        logic [5:0] g;
        for (int i = 0; i < 19; i++) begin
            if (i == 0)       apply(1'b0, pk(3'b110, 0, 0, 0), 6'b110_100);
            else if (i <= 16) apply(1'b0, 12'h000, 6'b010_100);
            else              apply(1'b0, 12'h000, 6'b000_001);
            @(posedge clk); #1;
            e = q.pop_front();
            g = {node, hi, cont, dec};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL decay step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    task automatic test_contention;
        logic [11:0] st[8];
        logic [5:0]  ex[8];
        logic [5:0]  e;
        logic [5:0]  g;
        st = '{pk(3'b110, 3'b111, 0, 0), pk(3'b110, 3'b111, 0, 0),
               pk(3'b110, 3'b111, 0, 0), pk(3'b110, 3'b101, 0, 0),
               pk(3'b100, 3'b101, 0, 0), pk(3'b010, 3'b011, 0, 0),
               pk(3'b110, 3'b100, 3'b110, 3'b111),
               pk(3'b111, 3'b111, 3'b101, 0)};
        ex = '{6'b111_010, 6'b111_010, 6'b111_010, 6'b110_100,
               6'b101_010, 6'b011_000, 6'b111_010, 6'b111_000};
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, st[i], ex[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            g = {node, hi, cont, dec};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL contention step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] st[8];
        logic [5:0]  ex[8];
        logic [5:0]  e;
        logic [5:0]  g;
        st = '{pk(3'b100, 0, 0, 0), pk(0, 3'b111, 0, 0),
               pk(0, 0, 3'b011, 0), pk(0, 0, 0, 3'b110),
               12'h000, pk(3'b101, 0, 0, 0),
               12'h000, pk(0, 3'b010, 0, 0)};
        ex = '{6'b100_100, 6'b111_000, 6'b011_000, 6'b110_100,
               6'b010_100, 6'b101_000, 6'b011_000, 6'b010_100};
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, st[i], ex[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            g = {node, hi, cont, dec};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    task automatic test_float_hold;
        logic [5:0] e;
        logic [5:0] g;
        for (int i = 0; i < 49; i++) begin
            if (i == 0)       apply(1'b0, pk(0, 0, 3'b100, 3'b011), 6'b100_100);
            else if (i <= 30) apply(1'b0, pk(0, 0, 0, 3'b011), 6'b011_000);
            else if (i <= 46) apply(1'b0, 12'h000, 6'b011_000);
            else              apply(1'b0, 12'h000, 6'b000_001);
            @(posedge clk); #1;
            e = q.pop_front();
            g = {node, hi, cont, dec};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL float_hold step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        logic [5:0] e;
        logic [5:0] g;
        for (int i = 0; i < 24; i++) begin
            if (i == 0)       apply(1'b0, pk(3'b111, 0, 0, 0), 6'b111_000);
            else if (i <= 4)  apply(1'b0, 12'h000, 6'b011_000);
            else if (i == 5)  apply(1'b1, 12'h000, 6'b000_001);
            else if (i == 6)  apply(1'b0, pk(3'b100, 0, 0, 0), 6'b100_100);
            else if (i <= 22) apply(1'b0, 12'h000, 6'b010_100);
            else              apply(1'b0, 12'h000, 6'b000_001);
            @(posedge clk); #1;
            e = q.pop_front();
            g = {node, hi, cont, dec};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid_hold step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    task automatic test_small;
        logic [2:0] st[4];
        logic [5:0] ex[4];
        logic [5:0] e;
        logic [5:0] g;
        st = '{3'b101, 3'b000, 3'b000, 3'b000};
        ex = '{6'b101_000, 6'b011_000, 6'b000_001, 6'b000_001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = 1'b0;
            drv   = '0;
            drv1  = st[i];
            q1.push_back(ex[i]);
            @(posedge clk); #1;
            e = q1.pop_front();
            g = {node1, hi1, cont1, dec1};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL small step %0d: got %b exp %b", i, g, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_decay;
        test_contention;
        test_back_to_back;
        test_float_hold;
        test_reset_mid_hold;
        test_small;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
